// File: rtl/calyx_run_controller.sv
// rtl/calyx_run_controller.sv - reset/go/done sequencer for one Calyx component
module calyx_run_controller #(
  parameter int RESET_CYCLES = 5,
  parameter int CYCLE_W      = 32,
  parameter int RUN_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [RUN_W-1:0]   num_runs,
  input  logic [CYCLE_W-1:0] timeout,
  output logic               dut_reset,
  output logic               dut_go,
  input  logic               dut_done,
  output logic               busy,
  output logic               finished,
  output logic               timed_out,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] total_cycles,
  output logic [RUN_W-1:0]   runs_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GO,
    S_GAP,
    S_FIN
  } state_t;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]    RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_MAX = '1;

  state_t             state, state_n;
  logic [RC_W-1:0]    rst_cnt, rst_cnt_n;
  logic [CYCLE_W-1:0] run_cnt, run_cnt_n;
  logic [RUN_W-1:0]   target, target_n;
  logic [CYCLE_W-1:0] timeout_q, timeout_q_n;

  logic               dut_reset_n, dut_go_n, busy_n, finished_n, timed_out_n;
  logic [CYCLE_W-1:0] cycle_count_n, total_cycles_n;
  logic [RUN_W-1:0]   runs_done_n;

  // Go-high cycles of the current run including this cycle; saturates.
  logic [CYCLE_W-1:0] cnt_inc;
  logic [CYCLE_W:0]   sum_wide;
  logic [CYCLE_W-1:0] total_sat;
  logic [RUN_W-1:0]   runs_inc;

  // Saturating arithmetic shared by the done path.
  always_comb begin
    cnt_inc   = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;
    sum_wide  = {1'b0, total_cycles} + {1'b0, cnt_inc};
    total_sat = sum_wide[CYCLE_W] ? CNT_MAX : sum_wide[CYCLE_W-1:0];
    runs_inc  = runs_done + 1'b1;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n        = state;
    rst_cnt_n      = rst_cnt;
    run_cnt_n      = run_cnt;
    target_n       = target;
    timeout_q_n    = timeout_q;
    dut_reset_n    = 1'b0;
    dut_go_n       = 1'b0;
    busy_n         = 1'b0;
    finished_n     = 1'b0;
    timed_out_n    = timed_out;
    cycle_count_n  = cycle_count;
    total_cycles_n = total_cycles;
    runs_done_n    = runs_done;

    case (state)
      S_IDLE: begin
        if (start) begin
          target_n       = (num_runs == '0) ? RUN_W'(1) : num_runs;
          timeout_q_n    = timeout;
          cycle_count_n  = '0;
          total_cycles_n = '0;
          runs_done_n    = '0;
          timed_out_n    = 1'b0;
          rst_cnt_n      = '0;
          dut_reset_n    = 1'b1;
          busy_n         = 1'b1;
          state_n        = S_RST;
        end
      end

      S_RST: begin
        busy_n = 1'b1;
        if (rst_cnt == RC_LAST) begin
          run_cnt_n = '0;
          dut_go_n  = 1'b1;
          state_n   = S_GO;
        end else begin
          rst_cnt_n   = rst_cnt + 1'b1;
          dut_reset_n = 1'b1;
        end
      end

      S_GO: begin
        busy_n    = 1'b1;
        run_cnt_n = cnt_inc;
        if (dut_done) begin
          // Done wins over a timeout landing on the same cycle.
          cycle_count_n  = cnt_inc;
          total_cycles_n = total_sat;
          runs_done_n    = runs_inc;
          if (runs_inc == target) begin
            finished_n = 1'b1;
            busy_n     = 1'b0;
            state_n    = S_FIN;
          end else begin
            state_n = S_GAP;
          end
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          timed_out_n   = 1'b1;
          cycle_count_n = timeout_q;
          finished_n    = 1'b1;
          busy_n        = 1'b0;
          state_n       = S_FIN;
        end else begin
          dut_go_n = 1'b1;
        end
      end

      S_GAP: begin
        busy_n    = 1'b1;
        run_cnt_n = '0;
        dut_go_n  = 1'b1;
        state_n   = S_GO;
      end

      S_FIN: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without a finished pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      run_cnt      <= '0;
      target       <= '0;
      timeout_q    <= '0;
      dut_reset    <= 1'b1;
      dut_go       <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      timed_out    <= 1'b0;
      cycle_count  <= '0;
      total_cycles <= '0;
      runs_done    <= '0;
    end else begin
      state        <= state_n;
      rst_cnt      <= rst_cnt_n;
      run_cnt      <= run_cnt_n;
      target       <= target_n;
      timeout_q    <= timeout_q_n;
      dut_reset    <= dut_reset_n;
      dut_go       <= dut_go_n;
      busy         <= busy_n;
      finished     <= finished_n;
      timed_out    <= timed_out_n;
      cycle_count  <= cycle_count_n;
      total_cycles <= total_cycles_n;
      runs_done    <= runs_done_n;
    end
  end

endmodule

// File: tb/tb_calyx_run_controller.sv
// tb/tb_calyx_run_controller.sv - timeline-model bench for calyx_run_controller
module tb_calyx_run_controller;

  localparam int R  = 5;
  localparam int CW = 32;
  localparam int RW = 8;
  localparam int N  = 170;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_runs = '0;
  logic [CW-1:0] timeout = '0;
  logic          dut_done = 1'b0;
  logic          dut_reset, dut_go, busy, finished, timed_out;
  logic [CW-1:0] cycle_count, total_cycles;
  logic [RW-1:0] runs_done;

  always #5 clk = ~clk;

  calyx_run_controller #(.RESET_CYCLES(R), .CYCLE_W(CW), .RUN_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .timeout(timeout),
    .dut_reset(dut_reset), .dut_go(dut_go), .dut_done(dut_done), .busy(busy),
    .finished(finished), .timed_out(timed_out), .cycle_count(cycle_count),
    .total_cycles(total_cycles), .runs_done(runs_done)
  );

  // Stimulus per cycle and expected outputs per cycle.
  bit drv_reset[N], drv_start[N], drv_done[N];
  int drv_nr[N], drv_tmo[N];
  bit e_rst[N], e_go[N], e_busy[N], e_fin[N], e_to[N];
  int e_cc[N], e_tot[N], e_rd[N];
  int m_cc, m_tot, m_rd, m_to;

  int lq_c[$], lq_s[$], lq_v[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic set_hold(input int from);
    for (int k = from; k < N; k++) begin
      e_cc[k] = m_cc; e_tot[k] = m_tot; e_rd[k] = m_rd; e_to[k] = m_to;
    end
  endtask

  // Lay out one whole sequence: reset window, go windows, gaps, finish.
  task automatic plan_seq(input int t, input int nr, input int tmo,
                          input int d0, input int d1, input int d2, output int fin);
    int d[3];
    int target, g, c;
    d[0] = d0; d[1] = d1; d[2] = d2;
    drv_start[t] = 1'b1; drv_nr[t] = nr; drv_tmo[t] = tmo;
    m_cc = 0; m_tot = 0; m_rd = 0; m_to = 0;
    set_hold(t + 1);
    for (int k = t + 1; k <= t + R; k++) e_rst[k] = 1'b1;
    target = (nr == 0) ? 1 : nr;
    g = t + R + 1;
    fin = -1;
    for (int r = 0; r < target && fin < 0; r++) begin
      if (tmo != 0 && (d[r] == 0 || d[r] > tmo)) begin
        for (int k = g; k < g + tmo; k++) e_go[k] = 1'b1;
        fin = g + tmo;
        m_cc = tmo; m_to = 1;
        set_hold(fin);
      end else begin
        c = g + d[r] - 1;
        for (int k = g; k <= c; k++) e_go[k] = 1'b1;
        drv_done[c] = 1'b1;
        m_cc = d[r]; m_tot = m_tot + d[r]; m_rd = r + 1;
        set_hold(c + 1);
        if (r == target - 1) fin = c + 1;
        else g = c + 2;
      end
    end
    for (int k = t + 1; k < fin; k++) e_busy[k] = 1'b1;
    e_fin[fin] = 1'b1;
  endtask

  // Controller reset asserted for len cycles starting at cycle x.
  task automatic plan_abort(input int x, input int len);
    for (int k = x; k < N; k++) drv_done[k] = 1'b0;
    for (int k = x + 1; k < N; k++) begin
      e_rst[k] = 1'b0; e_go[k] = 1'b0; e_busy[k] = 1'b0; e_fin[k] = 1'b0;
    end
    for (int k = x; k < x + len; k++) drv_reset[k] = 1'b1;
    for (int k = x + 1; k <= x + len; k++) e_rst[k] = 1'b1;
    m_cc = 0; m_tot = 0; m_rd = 0; m_to = 0;
    set_hold(x + 1);
  endtask

  task automatic add_lit(input int c, input int s, input int v);
    lq_c.push_back(c); lq_s.push_back(s); lq_v.push_back(v);
  endtask

  function automatic longint sig(input int s);
    case (s)
      0: return longint'(dut_reset);
      1: return longint'(dut_go);
      2: return longint'(busy);
      3: return longint'(finished);
      4: return longint'(timed_out);
      5: return longint'(cycle_count);
      6: return longint'(total_cycles);
      default: return longint'(runs_done);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, k, got, want);
  endtask

  initial begin
    int f;
    for (int k = 0; k < N; k++) begin
      drv_nr[k] = 5; drv_tmo[k] = 2;
    end
    for (int k = 0; k <= 2; k++) drv_reset[k] = 1'b1;
    for (int k = 0; k <= 3; k++) e_rst[k] = 1'b1;

    plan_seq(10, 1, 0, 5, 0, 0, f);
    plan_seq(22, 3, 0, 4, 4, 4, f);
    drv_done[25] = 1'b1;
    drv_done[32] = 1'b1;
    drv_start[30] = 1'b1;
    drv_done[46] = 1'b1;
    plan_seq(50, 2, 8, 0, 0, 0, f);
    plan_seq(70, 1, 4, 4, 0, 0, f);
    plan_seq(90, 0, 0, 3, 0, 0, f);
    drv_done[101] = 1'b1;
    plan_seq(110, 2, 0, 6, 6, 0, f);
    plan_abort(118, 2);
    plan_seq(130, 1, 0, 2, 0, 0, f);
    for (int k = 131; k <= 139; k++) drv_start[k] = 1'b1;
    plan_seq(139, 1, 0, 1, 0, 0, f);

    // Hand-derived points on the timeline (signal codes: see sig()).
    add_lit(0, 0, 1);   add_lit(0, 2, 0);   add_lit(4, 0, 0);
    add_lit(15, 0, 1);  add_lit(16, 0, 0);  add_lit(16, 1, 1);
    add_lit(20, 1, 1);  add_lit(21, 1, 0);  add_lit(21, 3, 1);
    add_lit(22, 5, 5);  add_lit(22, 6, 5);  add_lit(22, 7, 1);
    add_lit(32, 1, 0);  add_lit(42, 3, 1);  add_lit(43, 6, 12);
    add_lit(43, 7, 3);  add_lit(63, 1, 1);  add_lit(64, 1, 0);
    add_lit(64, 3, 1);  add_lit(65, 4, 1);  add_lit(65, 5, 8);
    add_lit(65, 7, 0);  add_lit(71, 4, 0);  add_lit(81, 4, 0);
    add_lit(81, 5, 4);  add_lit(81, 7, 1);  add_lit(99, 3, 1);
    add_lit(100, 7, 1); add_lit(119, 0, 1); add_lit(119, 1, 0);
    add_lit(119, 2, 0); add_lit(121, 0, 0); add_lit(138, 3, 1);
    add_lit(146, 3, 1); add_lit(147, 5, 1);

    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("dut_reset", k, longint'(dut_reset), longint'(e_rst[k]));
      chk("dut_go", k, longint'(dut_go), longint'(e_go[k]));
      chk("busy", k, longint'(busy), longint'(e_busy[k]));
      chk("finished", k, longint'(finished), longint'(e_fin[k]));
      chk("timed_out", k, longint'(timed_out), longint'(e_to[k]));
      chk("cycle_count", k, longint'(cycle_count), longint'(e_cc[k]));
      chk("total_cycles", k, longint'(total_cycles), longint'(e_tot[k]));
      chk("runs_done", k, longint'(runs_done), longint'(e_rd[k]));
      for (int i = 0; i < lq_c.size(); i++) begin
        if (lq_c[i] == k) chk("literal", k, sig(lq_s[i]), longint'(lq_v[i]));
      end
      reset    = drv_reset[k];
      start    = drv_start[k];
      dut_done = drv_done[k];
      num_runs = RW'(drv_nr[k]);
      timeout  = CW'(drv_tmo[k]);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calyx_run_controller.md
Name: calyx_run_controller

Overview:
- Synthesizable sequencer that drives one Calyx component through its reset/go/done protocol.
- Sequence per start: hold the component in reset for a fixed number of cycles, then issue one or more go/done invocations back-to-back.
- Measures per-run and total cycle counts and enforces an optional per-run timeout.
- Sits between the top-level harness or host logic and a Calyx `main`, replacing open-loop clock/go sequencing.

Parameters:
- RESET_CYCLES, 5: cycles dut_reset is held high after start; must be ≥1.
- CYCLE_W, 32: width of the cycle counters and the timeout input.
- RUN_W, 8: width of the run-count input and output.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high controller reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- num_runs  in  RUN_W  invocations per sequence, latched at start; 0 is treated as 1.
- timeout  in  CYCLE_W  max go-high cycles per run, latched at start; 0 disables the timeout.
- dut_reset  out  1  reset to the component.
- dut_go  out  1  go to the component.
- dut_done  in  1  done from the component.
- busy  out  1  high from the cycle after start is accepted until finished.
- finished  out  1  one-cycle pulse when the sequence ends.
- timed_out  out  1  sticky; set on timeout, cleared when the next start is accepted.
- cycle_count  out  CYCLE_W  go-high cycles of the most recent run.
- total_cycles  out  CYCLE_W  sum of cycle_count over the sequence.
- runs_done  out  RUN_W  runs completed by done in this sequence.

Behaviour:
- All outputs are registered. On reset: state=IDLE, dut_reset=1, all other outputs 0.
  - Reset has priority over every other event and aborts any sequence mid-operation; no finished pulse is issued.
- IDLE:
  - dut_reset=0, dut_go=0.
  - start=1 at cycle t → latch num_runs/timeout; clear counters and timed_out; go to RST.
- RST:
  - dut_reset=1 and busy=1 during cycles t+1 .. t+RESET_CYCLES, then go to GO.
- GO:
  - dut_go=1 from cycle t+RESET_CYCLES+1; the run counter increments every GO cycle, saturating at all-ones.
  - cycle_count counts go-high cycles, including the cycle in which dut_done is sampled high.
  - On dut_done=1 at cycle c:
    - cycle_count updates; total_cycles += run count (saturating); runs_done += 1.
    - dut_go=0 at c+1.
    - If runs_done reaches the latched target → FIN; else → GAP.
  - Timeout: if timeout≠0 and the run counter equals timeout with dut_done=0:
    - set timed_out=1, cycle_count=timeout, dut_go=0 next cycle, → FIN.
    - Remaining runs are skipped.
  - If done and the timeout boundary occur in the same cycle, done wins (no timeout).
- GAP:
  - Exactly one cycle with dut_go=0, then re-enter GO with the run counter cleared.
  - dut_reset is not reasserted between runs.
- FIN:
  - finished=1 for one cycle and busy=0 → IDLE.
  - cycle_count, total_cycles, runs_done and timed_out hold until the next accepted start.
- Ignored inputs:
  - dut_done outside GO is ignored.
  - start outside IDLE is ignored; start held high re-triggers only on returning to IDLE.
- Back-to-back: a start sampled in the cycle after the finished pulse is accepted (IDLE lasts ≥1 cycle).

Test Plan:
- Single run: RESET_CYCLES=5, num_runs=1, timeout=0; start at cycle 10, done at cycle 20 → dut_reset high 11–15, dut_go high 16–20, finished at 21, cycle_count=5, total_cycles=5, runs_done=1, timed_out=0.
- Multi-run: num_runs=3, done on the 4th go cycle of each run → three 4-cycle go windows each separated by one low cycle, dut_reset only once; total_cycles=12, runs_done=3, single finished pulse.
- Timeout: timeout=8, dut_done held 0 → dut_go high exactly 8 cycles, timed_out=1, cycle_count=8, runs_done=0, finished the cycle after go drops; next start clears timed_out.
- Done on timeout boundary: timeout=4, done on the 4th go cycle → timed_out=0, cycle_count=4, runs_done=1.
- Reset mid-run: assert reset during GO → next cycle dut_reset=1, dut_go=0, busy=0, no finished pulse; after release the controller idles until start.
- Corner inputs: num_runs=0 behaves as 1; start pulsed while busy and dut_done pulsed in IDLE/RST have no effect on state or counters.
